// File: rtl/vr_sync_fifo_pkg.sv
// Shared sizing helpers and default word type for the valid/ready synchronous FIFO.
package vr_sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  typedef logic [DEF_DATA_W-1:0] word_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/vr_sync_fifo_if.sv
// Upstream/downstream handshake bundle plus flush and status for vr_sync_fifo.
interface vr_sync_fifo_if
  import vr_sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  level;
  logic              almost_full;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, almost_full
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level, almost_full
  );

endinterface

// File: rtl/vr_sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, one synchronous write port, one asynchronous read port.
module vr_fifo_mem
  import vr_sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are deliberately not reset; readers are gated by out_valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vr_sync_fifo.sv
// Single-clock first-word-fall-through valid/ready FIFO with level, almost-full and flush.
module vr_sync_fifo
  import vr_sync_fifo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic            clk,
  input  logic            rst,
  vr_sync_fifo_if.slave   fifo_if
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_THRESH);

  if ((DATA_W < 1) || !is_pow2(DEPTH) || (AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_param_err
    $error("vr_sync_fifo: illegal parameters DATA_W=%0d DEPTH=%0d AFULL_THRESH=%0d",
           DATA_W, DEPTH, AFULL_THRESH);
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, wr_en;

  // All handshake outputs come from registered count; in_ready also drops asynchronously on rst.
  assign fifo_if.in_ready    = !rst && (count_q != FULL_CNT);
  assign fifo_if.out_valid   = (count_q != '0);
  assign fifo_if.level       = count_q;
  assign fifo_if.almost_full = (count_q >= AF_CNT);

  assign push  = fifo_if.in_valid  & fifo_if.in_ready;
  assign pop   = fifo_if.out_valid & fifo_if.out_ready;
  assign wr_en = push & !fifo_if.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  vr_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_if.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (fifo_if.out_data)
  );

endmodule

// File: tb/tb_vr_sync_fifo.sv
// Randomized and directed bench for vr_sync_fifo against a queue-based reference model.
module tb_vr_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vr_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  vr_sync_fifo #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_if (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: occupancy is simply the queue length; head word is q[0].
  task automatic check_outputs();
    chk("in_ready",    32'(bus.in_ready),    32'(!rst && (q.size() != DEPTH)));
    chk("out_valid",   32'(bus.out_valid),   32'(q.size() != 0));
    chk("level",       32'(bus.level),       32'(q.size()));
    chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
    if (q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(q[0]));
  endtask

  task automatic cycle(output bit accepted);
    bit do_push, do_pop, fl;
    logic [DATA_W-1:0] d;
    check_outputs();
    do_push  = bus.in_valid && (q.size() != DEPTH);
    do_pop   = bus.out_ready && (q.size() != 0);
    fl       = bus.flush;
    d        = bus.in_data;
    accepted = do_push && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    #1;
  endtask

  task automatic step();
    bit a;
    cycle(a);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit acc;
    bit holding;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),    32'd0);
    chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
    chk("rst_level",     32'(bus.level),       32'd0);
    chk("rst_afull",     32'(bus.almost_full), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word latency
    bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    step();
    bus.in_valid = 1'b0;
    chk("a5_valid", 32'(bus.out_valid), 32'd1);
    chk("a5_data",  32'(bus.out_data),  32'hA5);
    chk("a5_level", 32'(bus.level),     32'd1);
    drain();

    // Fill to FULL
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("full_level",    32'(bus.level),       32'd8);
    chk("full_in_ready", 32'(bus.in_ready),    32'd0);
    chk("full_afull",    32'(bus.almost_full), 32'd1);

    // Push and pop on FULL: only the pop completes
    bus.in_valid = 1'b1; bus.in_data = 8'h08; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("fullpp_level", 32'(bus.level),    32'd7);
    chk("fullpp_head",  32'(bus.out_data), 32'h01);
    chk("fullpp_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("fullpp_late_push", 32'(bus.level), 32'd8);
    drain();

    // Streaming 0x10..0x23 with constant level 1
    for (int k = 0; k <= 20; k++) begin
      bus.in_valid  = (k < 20);
      bus.in_data   = 8'(8'h10 + k);
      bus.out_ready = (k > 0);
      step();
      if (k > 0 && k < 20) chk("stream_level", 32'(bus.level), 32'd1);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;

    // Flush at level 5 discards the concurrent push
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h30 + i);
      step();
    end
    bus.flush = 1'b1; bus.in_data = 8'hFF;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_level", 32'(bus.level),     32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'h40;
    step();
    bus.in_valid = 1'b0;
    chk("after_flush_head", 32'(bus.out_data), 32'h40);
    drain();

    // Randomized traffic with upstream hold rule
    holding = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!holding) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (c > 300) bus.out_ready = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 40) == 0);
      cycle(acc);
      holding = bus.in_valid && !acc && !bus.flush;
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drain();

    // Async reset at level 4
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h50 + i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_level", 32'(bus.level), 32'd4);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready",  32'(bus.in_ready),    32'd0);
    chk("arst_out_valid", 32'(bus.out_valid),   32'd0);
    chk("arst_level",     32'(bus.level),       32'd0);
    chk("arst_afull",     32'(bus.almost_full), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_release_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    step();
    bus.in_valid = 1'b0;
    chk("arst_new_head", 32'(bus.out_data), 32'h77);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
